// File: rtl/regfile_write_sched.sv
// Register file write-port scheduler: merges WB, link (PC + offset) and mul/div writes
// onto one registered write port, keeping pipeline writes in order through a 2-entry buffer.
module regfile_write_sched #(
   parameter int LINK_OFFSET = 8,
   parameter int MD_STARVE   = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        lnk_we,
   input  logic [4:0]  lnk_addr,
   input  logic [31:0] lnk_pc,
   input  logic        md_valid,
   input  logic [4:0]  md_addr,
   input  logic [31:0] md_data,
   output logic        md_ready,
   output logic        stall_o,
   output logic        rf_we,
   output logic [4:0]  rf_addr,
   output logic [31:0] rf_data,
   output logic [1:0]  pend_cnt,
   output logic        overflow_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STARVE = 2'd2
   } state_t;

   state_t      state_r, state_s;
   logic [3:0]  wait_cnt_r, wait_cnt_s;
   logic [1:0]  cnt_r, cnt_s;
   logic [4:0]  addr0_r, addr1_r, addr0_s, addr1_s;
   logic [31:0] data0_r, data1_r, data0_s, data1_s;
   logic        drop_s;

   logic        wb_eff_s, lnk_eff_s, empty_s, hs_s, wait_s;
   logic [31:0] lnk_val_s;
   logic        iss_we_s;
   logic [4:0]  iss_addr_s;
   logic [31:0] iss_data_s;
   logic        c0_v_s, c1_v_s;
   logic [4:0]  c0_addr_s, c1_addr_s;
   logic [31:0] c0_data_s, c1_data_s;

   // Writes to $0 never count as requests.
   assign wb_eff_s  = wb_we && (wb_addr != 5'd0);
   assign lnk_eff_s = lnk_we && (lnk_addr != 5'd0);
   assign lnk_val_s = lnk_pc + 32'(LINK_OFFSET);
   assign empty_s   = (cnt_r == 2'd0);
   assign md_ready  = empty_s && !wb_eff_s && !lnk_eff_s;
   assign hs_s      = md_valid && md_ready;
   assign wait_s    = md_valid && !md_ready;
   assign stall_o   = (cnt_r != 2'd0) || (state_r == ST_STARVE);
   assign pend_cnt  = cnt_r;

   // Pick the single write to issue: buffer head, then wb, then lnk, then md.
   always_comb begin
      iss_we_s   = 1'b0;
      iss_addr_s = rf_addr;
      iss_data_s = rf_data;
      if (!empty_s) begin
         iss_we_s   = 1'b1;
         iss_addr_s = addr0_r;
         iss_data_s = data0_r;
      end else if (wb_eff_s) begin
         iss_we_s   = 1'b1;
         iss_addr_s = wb_addr;
         iss_data_s = wb_data;
      end else if (lnk_eff_s) begin
         iss_we_s   = 1'b1;
         iss_addr_s = lnk_addr;
         iss_data_s = lnk_val_s;
      end else if (hs_s) begin
         iss_we_s   = 1'b1;
         iss_addr_s = md_addr;
         iss_data_s = md_data;
      end else begin
         iss_we_s   = 1'b0;
      end
   end

   // Collect un-issued pipeline requests (wb before lnk) and update the buffer.
   always_comb begin
      c0_v_s    = 1'b0;
      c0_addr_s = 5'd0;
      c0_data_s = 32'd0;
      c1_v_s    = 1'b0;
      c1_addr_s = 5'd0;
      c1_data_s = 32'd0;
      if (wb_eff_s && !empty_s) begin
         c0_v_s    = 1'b1;
         c0_addr_s = wb_addr;
         c0_data_s = wb_data;
         c1_v_s    = lnk_eff_s;
         c1_addr_s = lnk_addr;
         c1_data_s = lnk_val_s;
      end else begin
         c0_v_s    = lnk_eff_s && (!empty_s || wb_eff_s);
         c0_addr_s = lnk_addr;
         c0_data_s = lnk_val_s;
      end
      // A non-empty buffer always dequeues its head, so at most one old entry survives.
      if (cnt_r == 2'd2) begin
         addr0_s = addr1_r;
         data0_s = data1_r;
         addr1_s = c0_addr_s;
         data1_s = c0_data_s;
         cnt_s   = c0_v_s ? 2'd2 : 2'd1;
         drop_s  = c1_v_s;
      end else begin
         addr0_s = c0_addr_s;
         data0_s = c0_data_s;
         addr1_s = c1_addr_s;
         data1_s = c1_data_s;
         cnt_s   = {1'b0, c0_v_s} + {1'b0, c1_v_s};
         drop_s  = 1'b0;
      end
   end

   // Starvation FSM next state: count ungranted md cycles, force a stall once starved.
   always_comb begin
      state_s    = state_r;
      wait_cnt_s = wait_cnt_r;
      case (state_r)
         ST_IDLE, ST_WAIT: begin
            if (wait_s) begin
               if (wait_cnt_r == 4'(MD_STARVE - 1)) begin
                  state_s = ST_STARVE;
               end else begin
                  state_s    = ST_WAIT;
                  wait_cnt_s = wait_cnt_r + 4'd1;
               end
            end else begin
               state_s    = ST_IDLE;
               wait_cnt_s = 4'd0;
            end
         end
         ST_STARVE: begin
            if (hs_s) begin
               state_s    = ST_IDLE;
               wait_cnt_s = 4'd0;
            end else begin
               state_s = ST_STARVE;
            end
         end
         default: begin
            state_s    = ST_IDLE;
            wait_cnt_s = 4'd0;
         end
      endcase
   end

   // State, buffer and registered write-port outputs.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         wait_cnt_r <= 4'd0;
         cnt_r      <= 2'd0;
         addr0_r    <= 5'd0;
         addr1_r    <= 5'd0;
         data0_r    <= 32'd0;
         data1_r    <= 32'd0;
         overflow_o <= 1'b0;
         rf_we      <= 1'b0;
         rf_addr    <= 5'd0;
         rf_data    <= 32'd0;
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
         cnt_r      <= cnt_s;
         addr0_r    <= addr0_s;
         addr1_r    <= addr1_s;
         data0_r    <= data0_s;
         data1_r    <= data1_s;
         overflow_o <= overflow_o | drop_s;
         rf_we      <= iss_we_s;
         rf_addr    <= iss_addr_s;
         rf_data    <= iss_data_s;
      end
   end

endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the pipeline register file. It merges three write sources onto the register file's single write port: the WB-stage result, the link write for jal/jalr (return address = PC + 8), and the multi-cycle mul/div result. Program order is preserved for pipeline writes through a 2-entry pending buffer, and the pipeline is stalled while that buffer holds anything. It sits between the WB stage, the mul/div unit and the register file write inputs.

## Interface
- LINK_OFFSET, 8: constant added to lnk_pc to form the link data.
- MD_STARVE, 8: number of cycles md_valid may wait ungranted before starve mode is entered (range 1..15).
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clock.
- wb_we  in  1  WB-stage write request.
- wb_addr  in  5  WB destination register.
- wb_data  in  32  WB write data.
- lnk_we  in  1  link write request (jal: addr 31; jalr: rd).
- lnk_addr  in  5  link destination register.
- lnk_pc  in  32  PC of the linking instruction.
- md_valid  in  1  mul/div result valid; held until accepted.
- md_addr  in  5  mul/div destination register.
- md_data  in  32  mul/div result.
- md_ready  out  1  mul/div grant; handshake completes when md_valid && md_ready.
- stall_o  out  1  pipeline must not present new wb/lnk requests.
- rf_we  out  1  register file write enable (registered).
- rf_addr  out  5  register file write address (registered).
- rf_data  out  32  register file write data (registered).
- pend_cnt  out  2  pending buffer occupancy, 0..2.
- overflow_o  out  1  sticky error flag; set when a request is dropped because the buffer is full.

## Operation
- Request validity:
  - A request is effective only when its enable is 1 and its address is nonzero.
  - Writes to $0 are discarded silently and consume no slot.
- Pending buffer: 2-entry FIFO holding {addr, data}.
  - Link entries store lnk_pc + LINK_OFFSET, computed mod 2^32 and wrapping.
- Per-cycle selection of the one write to issue, in priority order:
  - (1) the buffer head, if the buffer is non-empty;
  - (2) otherwise the incoming wb request;
  - (3) otherwise the incoming lnk request;
  - (4) otherwise md, if md_valid.
- Enqueue rules:
  - Every effective incoming wb/lnk request not issued this cycle is enqueued.
  - When both are enqueued, wb goes first, then lnk.
  - Occupancy update: count_next = count + enq − deq.
  - If the buffer would exceed 2 entries, the excess request(s) are dropped (lnk first, then wb) and overflow_o is set. overflow_o stays set until reset.
- md_ready = 1 only when all of the following hold:
  - the buffer is empty;
  - no effective wb request is present;
  - no effective lnk request is present.
  - md_ready is combinational from current state and inputs.
- stall_o = (pend_cnt != 0) || starve.
- Starvation FSM (states IDLE, WAIT, STARVE):
  - IDLE → WAIT when md_valid && !md_ready.
  - WAIT: a counter increments each cycle md_valid && !md_ready. At count == MD_STARVE−1 the FSM → STARVE.
  - WAIT → IDLE on an md handshake or when md_valid drops; the counter clears.
  - STARVE: starve = 1, so stall_o = 1. The FSM stays in STARVE until the md handshake completes, then → IDLE and the counter clears.
- Reset (reset = 0 at posedge):
  - rf_we = 0, rf_addr = 0, rf_data = 0.
  - Buffer empty, pend_cnt = 0, overflow_o = 0, FSM = IDLE, counter = 0.
  - Therefore stall_o = 0 after reset, and md_ready follows its combinational rule.
  - Reset mid-operation discards buffered writes and any in-flight md grant. The mul/div unit must re-present its result.

## Timing
- Issue latency: the write selected in cycle N appears on rf_we/rf_addr/rf_data after posedge N+1 and is held for exactly one cycle.
- rf_we = 0 in any cycle with nothing to issue. rf_addr/rf_data hold their last value when rf_we = 0.
- pend_cnt, stall_o, overflow_o and the FSM update on the same posedge as the enqueue/dequeue that changes them.
- Simultaneous wb + lnk with an empty buffer:
  - wb issues at N+1;
  - lnk issues at N+2;
  - stall_o = 1 during cycle N+1 only.
- Boundary conditions:
  - Same address on wb and lnk in one cycle: both writes occur, wb first, so lnk's value is final.
  - md arriving in the same cycle as a pipeline request loses that cycle. It is never granted while the buffer is non-empty.

## Test plan
- Reset, then wb_we=1, addr=5, data=0xDEADBEEF for one cycle → rf_we=1, rf_addr=5, rf_data=0xDEADBEEF one cycle later; pend_cnt stays 0.
- wb (addr 2, 0x11) and lnk (addr 31, pc 0x00003000) in the same cycle → rf writes (2, 0x11) then (31, 0x00003008) on consecutive cycles; stall_o=1 for exactly one cycle.
- wb_we=1, addr=0, data=0x1234 → rf_we stays 0, md_ready unaffected; lnk_pc=0xFFFFFFFC → link data 0x00000004.
- md_valid held with wb requests every cycle, MD_STARVE=8 → stall_o rises after 8 waiting cycles; once the buffer drains, md_ready=1 and the md write issues; FSM returns to IDLE.
- Three back-to-back wb+lnk pairs presented despite stall_o → third pair partially dropped, overflow_o=1 and sticky; no out-of-order rf writes.
- reset=0 asserted while pend_cnt=2 → next cycle pend_cnt=0, rf_we=0, stall_o=0, overflow_o=0.
